// File: rtl/fpu_result_select.sv
// FPU result selector: picks a unit result, compare flags or an error entry per opcode and queues it in a 2-entry in-order buffer.
// Optional macro FPU_RESULT_SELECT_CMP_EN enables the compare opcode (in_opc == NUM_UNITS) and the out_aeb/agb/alb flags.
module fpu_result_select #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 4,
  parameter int OPC_W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPC_W-1:0]           in_opc,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_res,
  input  logic                       cmp_eq,
  input  logic                       cmp_gt,
  input  logic                       cmp_lt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_aeb,
  output logic                       out_agb,
  output logic                       out_alb,
  output logic                       out_err,
  output logic [7:0]                 err_cnt
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             accept, pop;
  logic [1:0]       count;
  logic             wr_ptr, rd_ptr;

  // Stage p0: decode the incoming opcode into a buffer entry
  logic [WIDTH-1:0] data_p0;
  logic [2:0]       flags_p0;
  logic             err_p0;

`ifdef FPU_RESULT_SELECT_CMP_EN
  localparam logic [OPC_W-1:0] CMP_OPC = OPC_W'(NUM_UNITS);
`else
  logic cmp_unused;
  assign cmp_unused = cmp_eq ^ cmp_gt ^ cmp_lt;
`endif

  always_comb begin
    data_p0  = '0;
    flags_p0 = 3'b000;
    err_p0   = 1'b1;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (in_opc == OPC_W'(k)) begin
        data_p0 = unit_res[k*WIDTH +: WIDTH];
        err_p0  = 1'b0;
      end
    end
`ifdef FPU_RESULT_SELECT_CMP_EN
    if (in_opc == CMP_OPC) begin
      flags_p0 = {cmp_eq, cmp_gt, cmp_lt};
      err_p0   = 1'b0;
    end
`endif
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Stage p1: buffer storage, written on accept; contents are don't-care until counted
  logic [WIDTH-1:0] data_p1  [2];
  logic [2:0]       flags_p1 [2];
  logic             err_p1   [2];

  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1[wr_ptr]  <= data_p0;
      flags_p1[wr_ptr] <= flags_p0;
      err_p1[wr_ptr]   <= err_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && err_p0) err_cnt <= sat_inc8(err_cnt);
    end
  end

  // Head entry drives the outputs; everything reads zero while the buffer is empty
  assign out_data = out_valid ? data_p1[rd_ptr] : '0;
  assign out_aeb  = out_valid & flags_p1[rd_ptr][2];
  assign out_agb  = out_valid & flags_p1[rd_ptr][1];
  assign out_alb  = out_valid & flags_p1[rd_ptr][0];
  assign out_err  = out_valid & err_p1[rd_ptr];

endmodule

// File: tb/tb_fpu_result_select.sv
// Directed bench for fpu_result_select with hand-computed expectations (default build, or with FPU_RESULT_SELECT_CMP_EN).
module tb_fpu_result_select;
  localparam int WIDTH = 32;
  localparam int NU    = 4;
  localparam int OW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [OW-1:0]     in_opc;
  logic [NU*WIDTH-1:0] unit_res;
  logic              cmp_eq, cmp_gt, cmp_lt;
  logic              out_valid, out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_aeb, out_agb, out_alb, out_err;
  logic [7:0]        err_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_err = 0;
  logic [31:0] exp_d;

  fpu_result_select #(.WIDTH(WIDTH), .NUM_UNITS(NU), .OPC_W(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .unit_res(unit_res), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_aeb(out_aeb), .out_agb(out_agb), .out_alb(out_alb), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opc = '0; unit_res = '0;
    cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_data", out_data, 32'd0);

    // single unit result
    unit_res = {32'h33333333, 32'h40490FDB, 32'h11111111, 32'h00000000};
    in_opc = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel_valid", {31'd0, out_valid}, 32'd1);
    chk("sel_data", out_data, 32'h40490FDB);
    chk("sel_flags", {29'd0, out_aeb, out_agb, out_alb}, 32'd0);
    chk("sel_err", {31'd0, out_err}, 32'd0);
    step();
    chk("sel_popped", {31'd0, out_valid}, 32'd0);
    chk("empty_data", out_data, 32'd0);

    // compare opcode (legal only with the macro)
    in_opc = 3'd4; cmp_gt = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; cmp_gt = 1'b0;
    chk("cmp_data", out_data, 32'd0);
`ifdef FPU_RESULT_SELECT_CMP_EN
    chk("cmp_flags", {29'd0, out_aeb, out_agb, out_alb}, 32'b010);
    chk("cmp_err", {31'd0, out_err}, 32'd0);
    chk("cmp_errcnt", {24'd0, err_cnt}, 32'd0);
`else
    exp_err = 1;
    chk("cmp_flags", {29'd0, out_aeb, out_agb, out_alb}, 32'd0);
    chk("cmp_err", {31'd0, out_err}, 32'd1);
    chk("cmp_errcnt", {24'd0, err_cnt}, 32'd1);
`endif
    step();

    // backpressure: three inputs, two fit
    out_ready = 1'b0;
    unit_res = {32'h0, 32'h0, 32'h2, 32'h1};
    in_opc = 3'd0; in_valid = 1'b1;
    step();
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    chk("bp_head1", out_data, 32'h1);
    in_opc = 3'd1;
    step();
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    chk("bp_head2", out_data, 32'h1);
    in_opc = 3'd0; unit_res = {32'h0, 32'h0, 32'h2, 32'h3};
    step();
    chk("bp_held", {31'd0, in_ready}, 32'd0);
    chk("bp_head3", out_data, 32'h1);
    out_ready = 1'b1;
    step();
    chk("bp_out2", out_data, 32'h2);
    chk("bp_rdy_up", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out3", out_data, 32'h3);
    chk("bp_v3", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // streaming, one entry per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < NU; k++) unit_res[k*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(i * 16 + k);
      in_opc = OW'(i % NU);
      exp_d = 32'hA000_0000 + 32'(i * 16 + (i % NU));
      step();
      chk("stream_data", out_data, exp_d);
      chk("stream_rdy", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", {31'd0, out_valid}, 32'd0);

    // err_cnt saturation
    in_opc = 3'd7; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      chk("sat_err", {31'd0, out_err}, 32'd1);
      chk("sat_cnt", {24'd0, err_cnt}, 32'(exp_err));
    end
    in_valid = 1'b0;
    step();
    chk("sat_final", {24'd0, err_cnt}, 32'd255);

    // reset with a full buffer and an accept attempt in the reset cycle
    out_ready = 1'b0; in_opc = 3'd0; in_valid = 1'b1;
    step(); step();
    chk("full_rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_ready", {31'd0, in_ready}, 32'd1);
    chk("rr_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("rr_data", out_data, 32'd0);
    in_valid = 1'b0;
    step();
    chk("rr_noghost", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpu_result_select.md
FPU_RESULT_SELECT -- requirements
Module: fpu_result_select

Interface
REQ-001 Parameter WIDTH, default 32, result word width in bits.
REQ-002 Parameter NUM_UNITS, default 4, number of arithmetic unit result inputs (add, sub, mul, div, ...).
REQ-003 Parameter OPC_W, default 3, opcode width; SHALL satisfy 2**OPC_W > NUM_UNITS.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  upstream result set and opcode valid.
REQ-008 in_ready  output  1  block can accept a result this cycle.
REQ-009 in_opc  input  OPC_W  operation selector.
REQ-010 unit_res  input  NUM_UNITS*WIDTH  packed unit results; unit k in bits [k*WIDTH +: WIDTH].
REQ-011 cmp_eq, cmp_gt, cmp_lt  input  1 each  comparator A==B, A>B, A<B.
REQ-012 out_valid  output  1  out_* fields hold a valid entry.
REQ-013 out_ready  input  1  downstream accepts the entry.
REQ-014 out_data  output  WIDTH  selected result.
REQ-015 out_aeb, out_agb, out_alb  output  1 each  compare flags of the entry.
REQ-016 out_err  output  1  entry came from an illegal opcode.
REQ-017 err_cnt  output  8  saturating count of accepted illegal opcodes.

Function
REQ-018 Accept SHALL occur when in_valid && in_ready at a rising edge; pop SHALL occur when out_valid && out_ready.
REQ-019 in_opc < NUM_UNITS: entry data = unit slice in_opc, flags 0, err 0.
REQ-020 in_opc == NUM_UNITS (compare): data 0, flags = cmp_eq/cmp_gt/cmp_lt as sampled, err 0.
REQ-021 in_opc > NUM_UNITS: data 0, flags 0, err 1; err_cnt increments by 1, holds at 255.
REQ-022 Entries SHALL be stored in a 2-entry in-order buffer (count 0..2); out_* SHALL be driven from the head entry only, registered, no combinational path from unit_res or in_opc to out_*.
REQ-023 Latency: entry accepted at edge N SHALL be visible with out_valid=1 after edge N when buffer was empty.
REQ-024 in_ready SHALL be 1 when count < 2, 0 when count == 2; it SHALL NOT depend combinationally on out_ready.
REQ-025 Simultaneous accept and pop at count 1: count stays 1, new entry becomes head next cycle.
REQ-026 Pop at count 2: second entry becomes head next cycle, in_ready rises next cycle.
REQ-027 out_valid=0: out_data and flags SHALL read 0; out_valid SHALL stay 1 and out_* stable until popped.
REQ-028 Write and read pointers are 1 bit and wrap 1->0.

Reset
REQ-029 On rst=1 at an edge: count=0, pointers=0, out_valid=0, out_data=0, flags=0, out_err=0, err_cnt=0, in_ready=1 the following cycle.
REQ-030 Reset mid-operation SHALL discard all buffered entries; an accept in the reset cycle SHALL be ignored.
REQ-031 Buffer storage contents need not be reset; only outputs above are defined.

Configuration
REQ-032 Macro FPU_RESULT_SELECT_CMP_EN: defined -> compare opcode, cmp_* inputs and out_aeb/out_agb/out_alb per REQ-020.
REQ-033 Without FPU_RESULT_SELECT_CMP_EN: ports remain, cmp_* ignored, flags tied 0, in_opc == NUM_UNITS treated as illegal per REQ-021.

Verification
REQ-034 opc=2, unit 2 = 0x40490FDB, out_ready=1 -> one cycle later out_valid=1, out_data=0x40490FDB, flags 0, err 0.
REQ-035 opc=4, cmp_gt=1 others 0 (CMP_EN defined) -> out_data=0, out_agb=1, out_aeb=0, out_alb=0; without macro -> out_err=1, err_cnt=1.
REQ-036 out_ready=0, three back-to-back valid inputs 0x1,0x2,0x3 on units 0/1/0 -> in_ready=0 after two accepts, third held; release out_ready -> outputs 0x1,0x2,0x3 in order, no loss or duplicate.
REQ-037 Continuous in_valid and out_ready=1 for 20 cycles -> one entry per cycle, count stays 1, in_ready constantly 1.
REQ-038 300 accepted opc=7 inputs -> err_cnt saturates at 255, out_err=1 on each entry.
REQ-039 Buffer full, assert rst one cycle -> next cycle out_valid=0, in_ready=1, err_cnt=0.
